tft_rgb_frame_monitor: RTL

Sink/checker for the parallel TFT RGB interface: R/G/B, den, hsync, vsync and dclk.
- Recovers frame geometry from the sync/enable stream.
- Classifies every active pixel (red / black / other) and reports per-frame statistics and error flags.
- Placed on the same clk as the display-controller pattern generator, it checks the generated frame in simulation or on-chip.

---
 rtl/tft_rgb_frame_monitor.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tft_rgb_frame_monitor.sv
// tft_rgb_frame_monitor: recovers TFT RGB frame geometry and per-frame pixel-class statistics.
// Define TFT_FRAME_MONITOR_CHECKSUM_EN to add a per-frame 32-bit pixel checksum output.
module tft_rgb_frame_monitor #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter bit USE_DCLK        = 1'b1,
    parameter int TIMEOUT_PIX     = 1048575,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       R,
    input  logic [7:0]       G,
    input  logic [7:0]       B,
    input  logic             den,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             dclk,
    output logic             locked,
    output logic             frame_valid,
    output logic [11:0]      active_w,
    output logic [10:0]      active_h,
    output logic [11:0]      h_total,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] black_cnt,
    output logic [CNT_W-1:0] other_cnt,
    output logic             err_len,
    output logic             err_sync,
    output logic             err_timeout
`ifdef TFT_FRAME_MONITOR_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);
    localparam int TW = $clog2(TIMEOUT_PIX + 1);
    typedef enum logic {IDLE, MEASURE} state_t;
    state_t state;
    logic dclk_q, stb, hs, vs, hs_q, vs_q, den_q, hs_edge, vs_edge, den_fall;
    logic is_red, is_blk, keep, cnt_pix, to_hit, first_run;
    logic [11:0] run_cnt, run_w, hsync_cnt, ht_acc, run_base, run_nx, run_w_nx, ht_nx;
    logic [10:0] lines, lines_nx;
    logic [CNT_W-1:0] red_a, blk_a, oth_a, red_s, blk_s, oth_s;
    logic [CNT_W-1:0] red_b, blk_b, oth_b, red_nx, blk_nx, oth_nx, red_sn, blk_sn, oth_sn;
    logic el_acc, es_acc, el_nx, es_nx;
    logic [TW-1:0] timeout_cnt, timeout_nx;
`ifdef TFT_FRAME_MONITOR_CHECKSUM_EN
    logic [31:0] cs_a, cs_s, cs_nx, cs_sn;
`endif
    assign stb      = USE_DCLK ? (dclk & ~dclk_q) : 1'b1;
    assign hs       = hsync ^ SYNC_ACTIVE_LOW;
    assign vs       = vsync ^ SYNC_ACTIVE_LOW;
    assign hs_edge  = hs & ~hs_q;
    assign vs_edge  = vs & ~vs_q;
    assign den_fall = den_q & ~den;
    assign is_red   = (R == 8'hFF) && (G == 8'h00) && (B == 8'h00);
    assign is_blk   = (R == 8'h00) && (G == 8'h00) && (B == 8'h00);
    assign to_hit   = (state == MEASURE) & ~vs_edge & (timeout_cnt == TW'(TIMEOUT_PIX - 1));
    // keep: strobe continues the current frame; otherwise accumulators restart from zero
    assign keep     = (state == MEASURE) & ~vs_edge & ~to_hit;
    assign cnt_pix  = (vs_edge | keep) & den;

    always_comb begin
        first_run  = den_fall & (lines == 11'd0);
        run_base   = keep ? run_cnt : 12'd0;
        run_nx     = cnt_pix ? run_base + 12'(~&run_base) : 12'd0;
        run_w_nx   = first_run ? run_cnt : run_w;
        lines_nx   = den_fall ? lines + 11'(~&lines) : lines;
        el_nx      = el_acc | (den_fall & ~first_run & (run_cnt != run_w));
        ht_nx      = hs_edge ? hsync_cnt : ht_acc;
        es_nx      = es_acc | (hs_edge & den);
        // snapshots at each den fall exclude a run still open when the frame closes
        red_sn     = den_fall ? red_a : red_s;
        blk_sn     = den_fall ? blk_a : blk_s;
        oth_sn     = den_fall ? oth_a : oth_s;
        red_b      = keep ? red_a : '0;
        blk_b      = keep ? blk_a : '0;
        oth_b      = keep ? oth_a : '0;
        red_nx     = red_b + CNT_W'(cnt_pix & is_red & ~&red_b);
        blk_nx     = blk_b + CNT_W'(cnt_pix & is_blk & ~&blk_b);
        oth_nx     = oth_b + CNT_W'(cnt_pix & ~is_red & ~is_blk & ~&oth_b);
        timeout_nx = keep ? timeout_cnt + TW'(1) : '0;
`ifdef TFT_FRAME_MONITOR_CHECKSUM_EN
        cs_sn      = den_fall ? cs_a : cs_s;
        cs_nx      = (keep ? cs_a : 32'd0) + (cnt_pix ? {8'd0, R, G, B} : 32'd0);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dclk_q      <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            den_q       <= 1'b0;
            locked      <= 1'b0;
            frame_valid <= 1'b0;
            err_timeout <= 1'b0;
            hsync_cnt   <= '0;
            run_cnt     <= '0;
            run_w       <= '0;
            lines       <= '0;
            ht_acc      <= '0;
            el_acc      <= 1'b0;
            es_acc      <= 1'b0;
            red_a       <= '0;
            blk_a       <= '0;
            oth_a       <= '0;
            red_s       <= '0;
            blk_s       <= '0;
            oth_s       <= '0;
            timeout_cnt <= '0;
            active_w    <= '0;
            active_h    <= '0;
            h_total     <= '0;
            red_cnt     <= '0;
            black_cnt   <= '0;
            other_cnt   <= '0;
            err_len     <= 1'b0;
            err_sync    <= 1'b0;
`ifdef TFT_FRAME_MONITOR_CHECKSUM_EN
            cs_a        <= '0;
            cs_s        <= '0;
            checksum    <= '0;
`endif
        end else begin
            dclk_q      <= dclk;
            frame_valid <= stb & (state == MEASURE) & vs_edge;
            err_timeout <= stb & to_hit;
            if (stb) begin
                hs_q        <= hs;
                vs_q        <= vs;
                den_q       <= den;
                hsync_cnt   <= hs_edge ? 12'd1 : hsync_cnt + 12'(~&hsync_cnt);
                run_cnt     <= run_nx;
                run_w       <= keep ? run_w_nx : '0;
                lines       <= keep ? lines_nx : '0;
                ht_acc      <= keep ? ht_nx : '0;
                el_acc      <= keep & el_nx;
                es_acc      <= keep & es_nx;
                red_a       <= red_nx;
                blk_a       <= blk_nx;
                oth_a       <= oth_nx;
                red_s       <= keep ? red_sn : '0;
                blk_s       <= keep ? blk_sn : '0;
                oth_s       <= keep ? oth_sn : '0;
                timeout_cnt <= timeout_nx;
`ifdef TFT_FRAME_MONITOR_CHECKSUM_EN
                cs_a        <= cs_nx;
                cs_s        <= keep ? cs_sn : '0;
`endif
                if (vs_edge) begin
                    state  <= MEASURE;
                    locked <= 1'b1;
                end else if (to_hit) begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
                if ((state == MEASURE) & vs_edge) begin
                    active_w  <= run_w_nx;
                    active_h  <= lines_nx;
                    h_total   <= ht_nx;
                    red_cnt   <= red_sn;
                    black_cnt <= blk_sn;
                    other_cnt <= oth_sn;
                    err_len   <= el_nx;
                    err_sync  <= es_nx;
`ifdef TFT_FRAME_MONITOR_CHECKSUM_EN
                    checksum  <= cs_sn;
`endif
                end
            end
        end
    end
endmodule
